// File: rtl/rv_issue_sequencer.sv
// rv_issue_sequencer: fetch-to-execute issue FIFO with RV32I format classification and branch/jump stall.
// Ports: clk, rst (async active-high); fetch_valid_i/fetch_instr_i/fetch_pc_i/fetch_ready_o from fetch;
//   issue_valid_o/issue_ready_i/issue_instr_o/issue_pc_o/issue_type_o to execute;
//   resolve_valid_i/resolve_taken_i from execute; illegal_o/illegal_pc_o drop report; count_o occupancy.
// Optional feature: define ISSUE_SEQ_ILLEGAL_CHECK_EN to drop unknown-opcode heads instead of issuing them.
module rv_issue_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_valid_i,
  input  logic [31:0]                   fetch_instr_i,
  input  logic [31:0]                   fetch_pc_i,
  output logic                          fetch_ready_o,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output logic [31:0]                   issue_instr_o,
  output logic [31:0]                   issue_pc_o,
  output logic [2:0]                    issue_type_o,
  input  logic                          resolve_valid_i,
  input  logic                          resolve_taken_i,
  output logic                          illegal_o,
  output logic [31:0]                   illegal_pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] WAIT_RES = 1'b1;
  logic [31:0] instr_q [FIFO_DEPTH];
  logic [31:0] pc_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [0:0] state;
  logic empty, legal, is_bj, push, pop, flush;
  logic [6:0] op;
  logic [2:0] raw_type;
  assign empty = count == '0;
  assign issue_instr_o = empty ? 32'd0 : instr_q[rd_ptr];
  assign issue_pc_o = empty ? 32'd0 : pc_q[rd_ptr];
  assign op = issue_instr_o[6:0];
  assign raw_type = op == 7'b0110011 ? 3'd0 :
                    op == 7'b0010011 ? 3'd1 :
                    op == 7'b0100011 ? 3'd2 :
                    op == 7'b1100011 ? 3'd3 :
                    op == 7'b0010111 ? 3'd4 :
                    op == 7'b1101111 ? 3'd5 : 3'd7;
  assign issue_type_o = empty ? 3'd0 : raw_type;
  assign is_bj = issue_type_o == 3'd3 || issue_type_o == 3'd5;
`ifdef ISSUE_SEQ_ILLEGAL_CHECK_EN
  assign legal = raw_type != 3'd7;
  assign illegal_o = state == RUN && !empty && !legal;
  assign illegal_pc_o = illegal_o ? issue_pc_o : 32'd0;
`else
  assign legal = 1'b1;
  assign illegal_o = 1'b0;
  assign illegal_pc_o = 32'd0;
`endif
  assign issue_valid_o = state == RUN && !empty && legal;
  assign fetch_ready_o = !rst && count < DEPTH_C;
  assign count_o = count;
  assign push = fetch_valid_i && fetch_ready_o;
  assign pop = (issue_valid_o && issue_ready_i) || illegal_o;
  // a taken resolution squashes everything buffered, including a beat arriving on the same edge
  assign flush = state == WAIT_RES && resolve_valid_i && resolve_taken_i;
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= fetch_instr_i;
      pc_q[wr_ptr] <= fetch_pc_i;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (state == RUN && issue_valid_o && issue_ready_i && is_bj) state <= WAIT_RES;
      else if (state == WAIT_RES && resolve_valid_i) state <= RUN;
    end
  end
endmodule

// File: tb/tb_rv_issue_sequencer.sv
// tb_rv_issue_sequencer: directed self-checking bench for rv_issue_sequencer (FIFO_DEPTH=4).
module tb_rv_issue_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fetch_valid_i = 1'b0;
  logic [31:0] fetch_instr_i = '0;
  logic [31:0] fetch_pc_i = '0;
  logic fetch_ready_o;
  logic issue_valid_o;
  logic issue_ready_i = 1'b0;
  logic [31:0] issue_instr_o;
  logic [31:0] issue_pc_o;
  logic [2:0] issue_type_o;
  logic resolve_valid_i = 1'b0;
  logic resolve_taken_i = 1'b0;
  logic illegal_o;
  logic [31:0] illegal_pc_o;
  logic [2:0] count_o;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] BEQ = 32'h00000063;
  rv_issue_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
    .fetch_ready_o(fetch_ready_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_pc_o(issue_pc_o), .issue_type_o(issue_type_o),
    .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .illegal_o(illegal_o), .illegal_pc_o(illegal_pc_o), .count_o(count_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid_i = v;
    fetch_instr_i = ins;
    fetch_pc_i = pc;
  endtask
  task automatic check_reset_values(input string tag);
    checks++;
    if (count_o !== 3'd0 || fetch_ready_o !== 1'b0 || issue_valid_o !== 1'b0 ||
        issue_instr_o !== 32'd0 || issue_pc_o !== 32'd0 || issue_type_o !== 3'd0 ||
        illegal_o !== 1'b0 || illegal_pc_o !== 32'd0) begin
      failures++;
      $display("FAIL %s: cnt=%0d rdy=%b vld=%b ins=%h pc=%h typ=%0d ill=%b ipc=%h, required all zero",
               tag, count_o, fetch_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, issue_type_o,
               illegal_o, illegal_pc_o);
    end
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    check_reset_values("reset_hold");
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b required 1", fetch_ready_o);
    end
  endtask
  task automatic test_single_addi();
    issue_ready_i = 1'b1;
    drive(1'b1, ADDI, 32'h0);
    tick();
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (issue_valid_o !== 1'b1 || issue_type_o !== 3'd1 || issue_pc_o !== 32'h0 ||
        issue_instr_o !== ADDI || count_o !== 3'd1) begin
      failures++;
      $display("FAIL addi_offer: vld=%b typ=%0d pc=%h ins=%h cnt=%0d required 1 1 0 %h 1",
               issue_valid_o, issue_type_o, issue_pc_o, issue_instr_o, count_o, ADDI);
    end
    tick();
    checks++;
    if (count_o !== 3'd0 || issue_valid_o !== 1'b0 || issue_type_o !== 3'd0) begin
      failures++;
      $display("FAIL addi_drain: cnt=%0d vld=%b typ=%0d required 0 0 0", count_o, issue_valid_o, issue_type_o);
    end
  endtask
  task automatic test_full();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 32'h00000033 | (32'(i + 1) << 7);
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], 32'h100 + 32'(i * 4));
      tick();
    end
    drive(1'b1, w[4], 32'h110);
    #1;
    checks++;
    if (count_o !== 3'd4 || fetch_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_state: cnt=%0d rdy=%b required 4 0", count_o, fetch_ready_o);
    end
    tick();
    checks++;
    if (count_o !== 3'd4 || issue_instr_o !== w[0] || issue_type_o !== 3'd0 || issue_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL full_hold: cnt=%0d ins=%h typ=%0d vld=%b required 4 %h 0 1",
               count_o, issue_instr_o, issue_type_o, issue_valid_o, w[0]);
    end
    issue_ready_i = 1'b1;
    tick();
    checks++;
    if (count_o !== 3'd3 || issue_instr_o !== w[1] || issue_pc_o !== 32'h104) begin
      failures++;
      $display("FAIL full_pop1: cnt=%0d ins=%h pc=%h required 3 %h 104", count_o, issue_instr_o, issue_pc_o, w[1]);
    end
    tick();
    drive(1'b0, '0, '0);
    checks++;
    if (count_o !== 3'd3 || issue_instr_o !== w[2]) begin
      failures++;
      $display("FAIL full_pushpop: cnt=%0d ins=%h required 3 %h", count_o, issue_instr_o, w[2]);
    end
    tick();
    tick();
    checks++;
    if (count_o !== 3'd1 || issue_instr_o !== w[4] || issue_pc_o !== 32'h110 || issue_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL full_fifth: cnt=%0d ins=%h pc=%h vld=%b required 1 %h 110 1",
               count_o, issue_instr_o, issue_pc_o, issue_valid_o, w[4]);
    end
    tick();
    checks++;
    if (count_o !== 3'd0) begin
      failures++;
      $display("FAIL full_empty: cnt=%0d required 0", count_o);
    end
  endtask
  task automatic enter_wait(input int n_addi);
    issue_ready_i = 1'b1;
    drive(1'b1, BEQ, 32'h10);
    tick();
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (issue_valid_o !== 1'b1 || issue_type_o !== 3'd3 || issue_pc_o !== 32'h10) begin
      failures++;
      $display("FAIL beq_offer: vld=%b typ=%0d pc=%h required 1 3 10", issue_valid_o, issue_type_o, issue_pc_o);
    end
    tick();
    for (int i = 0; i < n_addi; i++) begin
      drive(1'b1, ADDI, 32'h14 + 32'(i * 4));
      tick();
    end
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (issue_valid_o !== 1'b0 || count_o !== 3'(n_addi)) begin
      failures++;
      $display("FAIL wait_stall: vld=%b cnt=%0d required 0 %0d", issue_valid_o, count_o, n_addi);
    end
  endtask
  task automatic test_branch_taken();
    enter_wait(2);
    resolve_valid_i = 1'b1;
    resolve_taken_i = 1'b1;
    drive(1'b1, ADDI, 32'h1C);
    tick();
    resolve_valid_i = 1'b0;
    resolve_taken_i = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (count_o !== 3'd0 || issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL taken_flush: cnt=%0d vld=%b required 0 0", count_o, issue_valid_o);
    end
    drive(1'b1, ADDI, 32'h40);
    tick();
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h40) begin
      failures++;
      $display("FAIL taken_run: vld=%b pc=%h required 1 40", issue_valid_o, issue_pc_o);
    end
    tick();
  endtask
  task automatic test_branch_not_taken();
    enter_wait(2);
    resolve_valid_i = 1'b1;
    resolve_taken_i = 1'b0;
    tick();
    resolve_valid_i = 1'b0;
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h14 || count_o !== 3'd2) begin
      failures++;
      $display("FAIL nt_first: vld=%b pc=%h cnt=%0d required 1 14 2", issue_valid_o, issue_pc_o, count_o);
    end
    tick();
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h18 || count_o !== 3'd1) begin
      failures++;
      $display("FAIL nt_second: vld=%b pc=%h cnt=%0d required 1 18 1", issue_valid_o, issue_pc_o, count_o);
    end
    tick();
    checks++;
    if (count_o !== 3'd0) begin
      failures++;
      $display("FAIL nt_drain: cnt=%0d required 0", count_o);
    end
  endtask
  task automatic test_other_opcode();
    issue_ready_i = 1'b1;
    drive(1'b1, 32'h0000007F, 32'h20);
    tick();
    drive(1'b0, '0, '0);
    #1;
`ifdef ISSUE_SEQ_ILLEGAL_CHECK_EN
    checks++;
    if (illegal_o !== 1'b1 || illegal_pc_o !== 32'h20 || issue_valid_o !== 1'b0 || count_o !== 3'd1) begin
      failures++;
      $display("FAIL illegal_drop: ill=%b ipc=%h vld=%b cnt=%0d required 1 20 0 1",
               illegal_o, illegal_pc_o, issue_valid_o, count_o);
    end
`else
    checks++;
    if (issue_valid_o !== 1'b1 || issue_type_o !== 3'd7 || illegal_o !== 1'b0 || illegal_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL other_issue: vld=%b typ=%0d ill=%b ipc=%h required 1 7 0 0",
               issue_valid_o, issue_type_o, illegal_o, illegal_pc_o);
    end
`endif
    tick();
    drive(1'b1, ADDI, 32'h24);
    checks++;
    if (count_o !== 3'd0 || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL other_pop: cnt=%0d ill=%b required 0 0", count_o, illegal_o);
    end
    tick();
    drive(1'b0, '0, '0);
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h24) begin
      failures++;
      $display("FAIL other_follow: vld=%b pc=%h required 1 24", issue_valid_o, issue_pc_o);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    enter_wait(3);
    drive(1'b1, ADDI, 32'h80);
    rst = 1'b1;
    #1;
    check_reset_values("reset_async");
    tick();
    check_reset_values("reset_mid_hold");
    rst = 1'b0;
    issue_ready_i = 1'b1;
    tick();
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h80 || count_o !== 3'd1) begin
      failures++;
      $display("FAIL reset_resume: vld=%b pc=%h cnt=%0d required 1 80 1", issue_valid_o, issue_pc_o, count_o);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_single_addi();
    test_full();
    test_branch_taken();
    test_branch_not_taken();
    test_other_opcode();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
